// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/redirect sequencing for the 5-stage RV32 core,
// with a memory-timeout FSM and stall/flush performance counters.
`default_nettype none

module hazard_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             im_req,
    input  logic             im_ready,
    input  logic             dm_req,
    input  logic             dm_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pc_redirect,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [WCW-1:0] WAIT_MAX  = WCW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WCW-1:0]   wait_cnt_q;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_count_q;

    logic mem_busy;
    logic load_use;
    logic in_err;
    logic branch_act;

    assign mem_busy = (im_req & ~im_ready) | (dm_req & ~dm_ready);
    assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                      ((id_use_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                       (id_use_rs2 && (id_rs2_addr == ex_rd_addr)));
    assign in_err     = (state_q == ST_ERR);
    // A branch seen during a freeze is held in EX and only acts once unfrozen.
    assign branch_act = ~in_err & ~mem_busy & ex_branch_taken;

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_redirect = 1'b0;
        if (in_err || mem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pc_redirect = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            if (!mem_busy) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            case (state_q)
                ST_RUN: begin
                    if (mem_busy) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!mem_busy) begin
                        state_q <= ST_RUN;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_ERR:  state_q <= ST_ERR;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_en && !in_err) stall_cycles_q <= stall_cycles_q + 1'b1;
            if (branch_act)        flush_count_q  <= flush_count_q + 1'b1;
        end
    end

    assign bus_err      = in_err;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector self-checking bench for hazard_ctrl (TIMEOUT=4, CNT_W=3).
`default_nettype none

module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic       im_req, im_ready, dm_req, dm_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, pc_redirect, bus_err;
    logic [2:0] stall_cycles, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd_addr      (ex_rd_addr),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .im_req          (im_req),
        .im_ready        (im_ready),
        .dm_req          (dm_req),
        .dm_ready        (dm_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .pc_redirect     (pc_redirect),
        .bus_err         (bus_err),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    wire [4:0] w_en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    wire [2:0] w_fl = {if_id_flush, id_ex_flush, pc_redirect};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0;
        im_req = 1'b0; im_ready = 1'b0; dm_req = 1'b0; dm_ready = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd_addr = rd;
        id_rs2_addr = 5'd5; id_use_rs2 = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        chk("rst_en", w_en, 5'b11111);
        chk("rst_fl", w_fl, 3'b000);
        chk("rst_err", bus_err, 1'b0);
        chk("rst_stall", stall_cycles, 3'd0);
        chk("rst_flush", flush_count, 3'd0);
        rst_n = 1'b1;
        tick();

        // Load-use on rs2: one bubble.
        set_load_use(5'd5);
        #1;
        chk("lu_en", w_en, 5'b00111);
        chk("lu_fl", w_fl, 3'b010);
        tick();
        chk("lu_stall", stall_cycles, 3'd1);
        idle();
        #1;
        chk("lu_after_en", w_en, 5'b11111);
        tick();
        chk("lu_after_stall", stall_cycles, 3'd1);

        // Destination x0 never creates a hazard.
        set_load_use(5'd0);
        #1;
        chk("x0_en", w_en, 5'b11111);
        chk("x0_fl", w_fl, 3'b000);
        tick();
        chk("x0_stall", stall_cycles, 3'd1);

        // Branch beats load-use.
        set_load_use(5'd5);
        ex_branch_taken = 1'b1;
        #1;
        chk("br_lu_en", w_en, 5'b11111);
        chk("br_lu_fl", w_fl, 3'b111);
        tick();
        chk("br_lu_flush", flush_count, 3'd1);
        chk("br_lu_stall", stall_cycles, 3'd1);
        idle();

        // DM wait for 3 cycles, resume in the dm_ready cycle.
        dm_req = 1'b1; dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dm_freeze_en", w_en, 5'b00000);
            chk("dm_freeze_fl", w_fl, 3'b000);
            tick();
        end
        chk("dm_stall", stall_cycles, 3'd4);
        dm_ready = 1'b1;
        #1;
        chk("dm_resume_en", w_en, 5'b11111);
        tick();
        chk("dm_resume_stall", stall_cycles, 3'd4);
        chk("dm_no_err", bus_err, 1'b0);
        idle();

        // Branch held across a 2-cycle IM freeze acts exactly once.
        ex_branch_taken = 1'b1;
        im_req = 1'b1; im_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("brf_hold_redir", pc_redirect, 1'b0);
            chk("brf_hold_en", w_en, 5'b00000);
            tick();
        end
        chk("brf_hold_flush", flush_count, 3'd1);
        im_ready = 1'b1;
        #1;
        chk("brf_act_fl", w_fl, 3'b111);
        chk("brf_act_en", w_en, 5'b11111);
        tick();
        chk("brf_flush", flush_count, 3'd2);
        chk("brf_stall", stall_cycles, 3'd6);
        idle();
        #1;
        chk("brf_once", pc_redirect, 1'b0);
        tick();

        // Timeout with TIMEOUT=4: ERR after the 4th busy edge.
        im_req = 1'b1; im_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("to_pre_err", bus_err, 1'b0);
        tick();
        chk("to_err", bus_err, 1'b1);
        chk("to_stall", stall_cycles, 3'd2);
        im_ready = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        chk("to_err_en", w_en, 5'b00000);
        chk("to_err_fl", w_fl, 3'b000);
        tick();
        tick();
        chk("to_err_sticky", bus_err, 1'b1);
        chk("to_err_stall_frozen", stall_cycles, 3'd2);
        chk("to_err_flush_frozen", flush_count, 3'd2);
        idle();

        // Asynchronous reset mid-cycle clears ERR and counters immediately.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_err", bus_err, 1'b0);
        chk("arst_stall", stall_cycles, 3'd0);
        chk("arst_flush", flush_count, 3'd0);
        chk("arst_en", w_en, 5'b11111);
        tick();
        rst_n = 1'b1;
        tick();

        // 9 load-use stalls on a 3-bit counter wrap to 1.
        for (int i = 0; i < 9; i++) begin
            set_load_use(5'd5);
            #1;
            chk("wrap_en", w_en, 5'b00111);
            tick();
        end
        chk("wrap_stall", stall_cycles, 3'd1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline sequencing controller for the 5-stage RV32 core.
- Generates per-stage register enables, flushes and the PC redirect select from four events: load-use hazards, taken branches in EX, and outstanding instruction-memory (IM) and data-memory (DM) handshakes.
- Runs a small FSM that times out stuck memory accesses, and keeps stall and flush performance counters.
- Sits beside the forwarding logic. It handles the load-use case that forwarding cannot cover, and it freezes the pipeline while memory is busy.

## Interface
Parameters:
- TIMEOUT, 1024: consecutive memory-busy cycles before a bus error.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- id_rs1_addr  in  5  rs1 of the instruction in ID.
- id_rs2_addr  in  5  rs2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd_addr  in  5  destination of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- im_req  in  1  IM fetch outstanding.
- im_ready  in  1  IM data valid this cycle.
- dm_req  in  1  DM access outstanding.
- dm_ready  in  1  DM access complete this cycle.
- pc_en  out  1  PC register update enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_flush  out  1  load a NOP into ID/EX.
- pc_redirect  out  1  PC mux selects the branch target.
- bus_err  out  1  sticky memory-timeout error.
- stall_cycles  out  CNT_W  count of cycles with pc_en=0 while not in ERR.
- flush_count  out  CNT_W  count of branch redirects.

## Operation

Hazard signals:
- mem_busy = (im_req & ~im_ready) | (dm_req & ~dm_ready).
- load_use = ex_mem_read & ex_rd_addr≠0 & ((id_use_rs1 & id_rs1_addr==ex_rd_addr) | (id_use_rs2 & id_rs2_addr==ex_rd_addr)).

FSM states are RUN, WAIT and ERR. Reset state is RUN.
- RUN → WAIT when mem_busy.
- WAIT → RUN when ~mem_busy.
- WAIT → ERR when mem_busy and wait_cnt==TIMEOUT-1.
- ERR is absorbing until reset.

wait_cnt (width clog2(TIMEOUT+1)):
- Increments on every cycle that mem_busy is high.
- Clears to 0 on any cycle that mem_busy is low.

Output priority is decided combinationally each cycle. The first matching row applies:
1. state==ERR: all five enables 0, flushes 0, pc_redirect 0, bus_err 1.
2. mem_busy (RUN or WAIT): all enables 0, flushes 0, pc_redirect 0. This is a full freeze with no bubbles.
3. ex_branch_taken: all enables 1, if_id_flush=1, id_ex_flush=1, pc_redirect=1. Branch wins over load_use, because the ID instruction is on the wrong path.
4. load_use: pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en/ex_mem_en/mem_wb_en=1, pc_redirect=0.
5. Otherwise: all enables 1, flushes 0, pc_redirect 0.

A taken branch arriving while frozen stays asserted, because EX is held. It is acted on in the first unfrozen cycle, exactly once.

Counters:
- stall_cycles increments on each cycle that pc_en==0 and state≠ERR.
- flush_count increments on each cycle where row 3 is active.
- Both wrap from 2^CNT_W-1 to 0.
- Neither counts while in ERR.

## Timing

- Enables, flushes and pc_redirect are combinational from the inputs and current state. There is zero latency: a freeze takes effect in the same cycle mem_busy rises.
- The pipeline resumes in the same cycle that mem_busy falls. The state returns to RUN on the following edge.
- A load-use hazard produces exactly one bubble. The next cycle the load is in MEM and load_use is 0 unless a new hazard arises.
- ERR is entered on the edge after the TIMEOUT-th consecutive busy cycle. bus_err is a decode of the ERR state (=1 while in ERR).
- Reset values: state RUN, wait_cnt 0, bus_err 0, stall_cycles 0, flush_count 0.
- While in reset, the remaining outputs follow rows 2–5 with state=RUN.
- Reset asserted mid-WAIT or in ERR returns the block to RUN immediately and asynchronously, and clears all counters.

## Test plan

- Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs2_addr=5, id_use_rs2=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles 0→1. Same stimulus with ex_rd_addr=0 → no stall.
- Branch plus load-use in the same cycle → if_id_flush=id_ex_flush=pc_redirect=1, pc_en=1; flush_count=1; stall_cycles unchanged.
- DM wait: dm_req=1, dm_ready=0 for 3 cycles, then dm_ready=1 → enables 0 for exactly 3 cycles; state WAIT then RUN; stall_cycles=3; resume in the dm_ready cycle.
- Timeout: TIMEOUT=4, im_req=1, im_ready=0 held → bus_err=1 after the 4th busy edge; all enables stay 0 after im_ready=1; rst_n low clears bus_err and the counters.
- Branch during freeze: ex_branch_taken=1 with mem_busy for 2 cycles → pc_redirect=0 for those 2 cycles, then 1 for one cycle; flush_count=1.
- Counter wrap: CNT_W=3, 9 load-use stalls → stall_cycles reads 1.
